// File: rtl/math_engine_if.sv
// Command/response channel bundle for math_engine.
// master: the instruction sequencer side; slave: the engine.
interface math_engine_if #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [REG_AW-1:0] cmd_rd;
  logic [REG_AW-1:0] cmd_rs1;
  logic [REG_AW-1:0] cmd_rs2;
  logic [WIDTH-1:0]  cmd_imm;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WIDTH-1:0]  rsp_result;
  logic              rsp_carry;
  logic              rsp_zero;
  logic              rsp_error;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_error
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_error
  );
endinterface

// File: rtl/math_engine.sv
// math_engine: handshaked register-to-register ALU with internal register file.
// Single-cycle ops write rd on the accept edge; DIV is a restoring divider
// producing one quotient bit per cycle, MSB first.
// Optional feature macro: MATH_ENGINE_DIV_EN builds the iterative divider.
// Without it every DIV completes in one cycle as result 0 / error 1, rd untouched.
module math_engine #(
  parameter  int WIDTH     = 32,
  parameter  int REG_COUNT = 32,
  localparam int REG_AW    = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              reset_n,
  math_engine_if.slave      bus,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
`ifdef MATH_ENGINE_DIV_EN
  localparam logic [1:0] S_DIV  = 2'd1;
`endif
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_MUL   = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_XOR   = 3'b110;
  localparam logic [2:0] OP_LOADI = 3'b111;

  logic [1:0]         state;
  logic [WIDTH-1:0]   regs [REG_COUNT];
  logic [WIDTH-1:0]   a, b;
  logic               accept;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   sc_result;
  logic               sc_carry, sc_error, sc_we;

  logic               we;
  logic [REG_AW-1:0]  wa;
  logic [WIDTH-1:0]   wd;

  logic [WIDTH-1:0]   rsp_result_q;
  logic               rsp_carry_q, rsp_zero_q, rsp_error_q;

  assign a        = regs[bus.cmd_rs1];
  assign b        = regs[bus.cmd_rs2];
  assign dbg_data = regs[dbg_addr];
  assign accept   = bus.cmd_valid && (state == S_IDLE);

  assign bus.cmd_ready  = (state == S_IDLE);
  assign bus.rsp_valid  = (state == S_RESP);
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_error  = rsp_error_q;

  // Single-cycle result; DIV here is the no-divide outcome (b==0 or divider absent)
  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    prod      = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    sc_result = '0;
    sc_carry  = 1'b0;
    sc_error  = 1'b0;
    sc_we     = 1'b1;
    case (bus.cmd_op)
      OP_ADD:   begin sc_result = sum[WIDTH-1:0]; sc_carry = sum[WIDTH]; sc_error = sum[WIDTH]; end
      OP_SUB:   begin sc_result = a - b; sc_carry = (a < b); sc_error = (a < b); end
      OP_MUL:   begin sc_result = prod[WIDTH-1:0]; sc_error = |prod[2*WIDTH-1:WIDTH]; end
      OP_DIV:   begin sc_error = 1'b1; sc_we = 1'b0; end
      OP_AND:   sc_result = a & b;
      OP_OR:    sc_result = a | b;
      OP_XOR:   sc_result = a ^ b;
      OP_LOADI: sc_result = bus.cmd_imm;
      default:  sc_result = '0;
    endcase
  end

`ifdef MATH_ENGINE_DIV_EN
  localparam int CW = $clog2(WIDTH) + 1;

  // div_q holds the dividend and shifts quotient bits in from the bottom
  logic [WIDTH-1:0]  div_q, div_d, div_rem, rem_nxt, q_nxt;
  logic [REG_AW-1:0] div_rd;
  logic [CW-1:0]     div_cnt;
  logic [WIDTH:0]    trial;
  logic              fits, div_start, div_last;

  // One restoring shift-subtract step
  always_comb begin
    trial     = {div_rem, div_q[WIDTH-1]};
    fits      = (trial >= {1'b0, div_d});
    rem_nxt   = fits ? WIDTH'(trial - {1'b0, div_d}) : trial[WIDTH-1:0];
    q_nxt     = {div_q[WIDTH-2:0], fits};
    div_start = accept && (bus.cmd_op == OP_DIV) && (b != '0);
    div_last  = (state == S_DIV) && (div_cnt == CW'(WIDTH - 1));
  end

  // Divider datapath; aborted by reset through the state register only
  always_ff @(posedge clk) begin
    if (div_start) begin
      div_q   <= a;
      div_d   <= b;
      div_rem <= '0;
      div_cnt <= '0;
      div_rd  <= bus.cmd_rd;
    end else if (state == S_DIV) begin
      div_q   <= q_nxt;
      div_rem <= rem_nxt;
      div_cnt <= div_cnt + CW'(1);
    end
  end
`endif

  // Single register-file write port: accept edge or final divide step
  always_comb begin
    we = accept && sc_we;
    wa = bus.cmd_rd;
    wd = sc_result;
`ifdef MATH_ENGINE_DIV_EN
    if (div_last) begin
      we = 1'b1;
      wa = div_rd;
      wd = q_nxt;
    end
`endif
  end

  // Register file, cleared on reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  // Control FSM and registered response
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_error_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.cmd_valid) begin
`ifdef MATH_ENGINE_DIV_EN
          if (div_start) state <= S_DIV;
          else
`endif
          begin
            rsp_result_q <= sc_result;
            rsp_carry_q  <= sc_carry;
            rsp_zero_q   <= (sc_result == '0);
            rsp_error_q  <= sc_error;
            state        <= S_RESP;
          end
        end
`ifdef MATH_ENGINE_DIV_EN
        S_DIV: if (div_last) begin
          rsp_result_q <= q_nxt;
          rsp_carry_q  <= 1'b0;
          rsp_zero_q   <= (q_nxt == '0);
          rsp_error_q  <= 1'b0;
          state        <= S_RESP;
        end
`endif
        S_RESP: if (bus.rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/math_engine.md
# math_engine

Parametrised, handshaked successor to the single-cycle math processor datapath. It accepts one register-to-register arithmetic/logic command at a time on a valid/ready command channel, reads operands from an internal register file, and executes. Divide is iterative and multi-cycle; every other op takes a single cycle. It writes the result back to the destination register and presents result plus flags on a valid/ready response channel. It sits between the instruction sequencer and the register-observing debug/test logic.

## Interface
Parameters:
- WIDTH, 32, datapath and register width; ≥ 4.
- REG_COUNT, 32, number of registers; power of two, ≥ 2.
- REG_AW (derived, $clog2(REG_COUNT)), register index width; not overridable.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command.
- cmd_op  in  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 LOADI.
- cmd_rd  in  REG_AW  destination register.
- cmd_rs1  in  REG_AW  operand A register.
- cmd_rs2  in  REG_AW  operand B register.
- cmd_imm  in  WIDTH  immediate; used by LOADI only.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_result  out  WIDTH  op result.
- rsp_carry  out  1  ADD carry-out / SUB borrow; 0 for all other ops.
- rsp_zero  out  1  rsp_result == 0.
- rsp_error  out  1  ADD carry, SUB borrow, MUL high half nonzero, or DIV by zero.
- dbg_addr  in  REG_AW  debug register select.
- dbg_data  out  WIDTH  combinational read of register dbg_addr.

## Operation
- FSM states: IDLE, DIV, RESP. cmd_ready = (state == IDLE). Reset state is IDLE.
- Command acceptance: cmd_valid && cmd_ready at a rising edge. rs1/rs2 values are sampled as they stand before that edge.
- Single-cycle ops (everything except DIV):
  - On the accept edge: compute the result, write rd, register the response, go to RESP.
- Arithmetic, all unsigned:
  - ADD: {carry, result} = a + b.
  - SUB: result = a − b mod 2^WIDTH; borrow = (a < b).
  - MUL: result = low WIDTH bits of a*b; error = (high WIDTH bits != 0).
  - Logic ops and LOADI: carry = 0, error = 0.
- rd write policy:
  - rd is written with the result for every op, including when error is set on ADD/SUB/MUL.
  - rd is NOT written when a DIV has b == 0.
- DIV (b != 0):
  - On the accept edge: latch a and b, clear the remainder and the iteration counter, go to DIV.
  - Each DIV cycle performs one restoring shift-subtract step, producing one quotient bit MSB-first.
  - After WIDTH steps: write the quotient to rd, present it with error = 0, go to RESP. The remainder is discarded.
- DIV by zero: behaves as a single-cycle op with result 0, error = 1, zero = 1, rd unchanged.
- RESP:
  - rsp_valid = 1; rsp_* held stable until rsp_ready.
  - On handshake, go to IDLE. cmd_ready rises the following cycle; there is no same-cycle re-accept.
- Register file: any register, including register 0, is writable. dbg_data reflects a write from the cycle after its edge.
- Reset (reset_n low at an edge):
  - All registers are cleared, state goes to IDLE, and any in-flight DIV is aborted with no write.
  - rsp_valid, rsp_result, and all flags go to 0; cmd_ready = 1 after the reset edge.

## Timing
- Single-cycle op accepted at edge N: rsp_valid is high after edge N; the rd write is visible on dbg_data after edge N.
- DIV accepted at edge N: steps occur at edges N+1 … N+WIDTH; rsp_valid and the rd write are visible after edge N+WIDTH.
- Best-case throughput: one command per 2 cycles, with rsp_ready tied high.
- cmd_ready, rsp_valid, and rsp_* are registered outputs; there is no combinational path from cmd_* or rsp_ready to any output. dbg_data is combinational from dbg_addr only.

## Configuration
- MATH_ENGINE_DIV_EN defined: the iterative divider and the DIV state are built; behaviour is as above.
- MATH_ENGINE_DIV_EN undefined: no divider logic and no DIV state. Every DIV op completes as a single-cycle op with result 0, error = 1, zero = 1, and rd unwritten.

## Test plan
- LOADI r1 = 0xFFFFFFFF, LOADI r2 = 1, then ADD r3 = r1 + r2 → result 0, carry 1, zero 1, error 1; dbg r3 = 0.
- r1 = 5, r2 = 7, SUB r4 → result 0xFFFFFFFE, carry 1, error 1.
- MUL with 0x10000 × 0x10000 → result 0, error 1.
- MUL with 3 × 4 → result 12, error 0.
- DIV 100 / 7 with rsp_ready tied high → rsp_valid exactly 32 cycles after accept; result 14; r rd = 14.
- DIV by zero → result 0, error 1; rd retains its prior value.
- Without the macro, any DIV → same result 0, error 1 single-cycle.
- Hold rsp_ready low for 10 cycles → rsp_* stable and cmd_ready 0 throughout; the handshake returns to IDLE.
- Assert reset_n low midway through a DIV → no rd write, rsp_valid 0, all registers 0, cmd_ready 1 after the reset edge.
